// File: rtl/axis_fifo_pkt_drop_if.sv
// AXI-Stream bundle used on both sides of the packet FIFO.
// tuser marks a bad packet on its tlast beat.
interface axis_fifo_pkt_drop_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tuser;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_fifo_pkt_drop.sv
// Store-and-forward AXI-Stream packet FIFO. Packets are released only once their
// tlast beat commits; errored or overflowing packets are discarded by rewinding wr_ptr.
module axis_fifo_pkt_drop #(
    parameter int WIDTH         = 32,
    parameter int DEEP          = 64,
    parameter int DEEP_BITS     = $clog2(DEEP),
    parameter bit DROP_OVERSIZE = 1'b1,
    parameter int DROP_CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    axis_fifo_pkt_drop_if.slave      s_rx,
    axis_fifo_pkt_drop_if.master     m_tx,
    output logic [DEEP_BITS:0]       fifo_used,
    output logic [DEEP_BITS:0]       pkt_count,
    output logic [DROP_CNT_BITS-1:0] drop_count,
    output logic                     drop_pulse
);
    localparam logic [DEEP_BITS:0] DEPTH   = (DEEP_BITS + 1)'(DEEP);
    localparam logic [DEEP_BITS:0] PTR_ONE = (DEEP_BITS + 1)'(1);

    function automatic logic [DROP_CNT_BITS-1:0] sat_inc(input logic [DROP_CNT_BITS-1:0] v);
        return (&v) ? v : v + DROP_CNT_BITS'(1);
    endfunction

    logic [WIDTH:0]     mem [DEEP];
    logic [DEEP_BITS:0] wr_ptr;
    logic [DEEP_BITS:0] wr_commit;
    logic [DEEP_BITS:0] rd_ptr;
    logic               ovf;
    logic               rdy_en;

    logic [WIDTH-1:0]   data_p1;
    logic               last_p1;
    logic               vld_p1;

    logic full;
    logic readable;
    logic wr_acc;
    logic wr_store;
    logic wr_end;
    logic drop;
    logic commit;
    logic pop;
    logic load;

    // Full and readable come from registered pointers only, so tready never depends on tready.
    always_comb begin
        fifo_used = wr_ptr - rd_ptr;
        full      = (fifo_used == DEPTH);
        readable  = (rd_ptr != wr_commit);
        wr_acc    = s_rx.tvalid && s_rx.tready;
        wr_store  = wr_acc && !full && !ovf;
        wr_end    = wr_acc && s_rx.tlast;
        drop      = wr_end && (ovf || full || s_rx.tuser);
        commit    = wr_end && !drop;
        pop       = vld_p1 && m_tx.tready;
        load      = readable && (!vld_p1 || m_tx.tready);
    end

    assign s_rx.tready = rdy_en && (!full || DROP_OVERSIZE);

    // Write stage p0: speculative write, commit on good tlast, rewind on drop
    always_ff @(posedge clk) begin
        if (wr_store)
            mem[wr_ptr[DEEP_BITS-1:0]] <= {s_rx.tlast, s_rx.tdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            wr_commit  <= '0;
            ovf        <= 1'b0;
            rdy_en     <= 1'b0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
            pkt_count  <= '0;
        end else begin
            rdy_en     <= 1'b1;
            drop_pulse <= drop;
            if (drop) begin
                wr_ptr     <= wr_commit;
                ovf        <= 1'b0;
                drop_count <= sat_inc(drop_count);
            end else begin
                if (wr_store)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (commit)
                    wr_commit <= wr_ptr + PTR_ONE;
                if (wr_acc && full)
                    ovf <= 1'b1;
            end
            if (commit && !(pop && last_p1))
                pkt_count <= pkt_count + PTR_ONE;
            else if (!commit && pop && last_p1)
                pkt_count <= pkt_count - PTR_ONE;
        end
    end

    // Read stage p1: the RAM's synchronous read lands directly in the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (load) begin
            {last_p1, data_p1} <= mem[rd_ptr[DEEP_BITS-1:0]];
            rd_ptr             <= rd_ptr + PTR_ONE;
            vld_p1             <= 1'b1;
        end else if (pop) begin
            vld_p1 <= 1'b0;
        end
    end

    assign m_tx.tdata  = data_p1;
    assign m_tx.tvalid = vld_p1;
    assign m_tx.tlast  = last_p1;
    assign m_tx.tuser  = 1'b0;
endmodule

// File: tb/tb_axis_fifo_pkt_drop.sv
// Directed bench for axis_fifo_pkt_drop: three configurations behind one stimulus mux,
// scoreboard of committed words checked as the FIFO emits them.
module tb_axis_fifo_pkt_drop;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tuser, m_tready;
    bit          rand_rdy;
    bit          busy;

    axis_fifo_pkt_drop_if #(.WIDTH(32)) rx0 ();
    axis_fifo_pkt_drop_if #(.WIDTH(32)) tx0 ();
    axis_fifo_pkt_drop_if #(.WIDTH(32)) rx1 ();
    axis_fifo_pkt_drop_if #(.WIDTH(32)) tx1 ();
    axis_fifo_pkt_drop_if #(.WIDTH(32)) rx2 ();
    axis_fifo_pkt_drop_if #(.WIDTH(32)) tx2 ();

    logic [6:0]  used0, pkt0;
    logic [4:0]  used1, pkt1, used2, pkt2;
    logic [15:0] dc0, dc1, dc2;
    logic        dp0, dp1, dp2;

    axis_fifo_pkt_drop #(.WIDTH(32), .DEEP(64), .DROP_OVERSIZE(1'b1), .DROP_CNT_BITS(16)) u_dut0 (
        .clk(clk), .rst(rst), .s_rx(rx0), .m_tx(tx0),
        .fifo_used(used0), .pkt_count(pkt0), .drop_count(dc0), .drop_pulse(dp0));
    axis_fifo_pkt_drop #(.WIDTH(32), .DEEP(16), .DROP_OVERSIZE(1'b1), .DROP_CNT_BITS(16)) u_dut1 (
        .clk(clk), .rst(rst), .s_rx(rx1), .m_tx(tx1),
        .fifo_used(used1), .pkt_count(pkt1), .drop_count(dc1), .drop_pulse(dp1));
    axis_fifo_pkt_drop #(.WIDTH(32), .DEEP(16), .DROP_OVERSIZE(1'b0), .DROP_CNT_BITS(16)) u_dut2 (
        .clk(clk), .rst(rst), .s_rx(rx2), .m_tx(tx2),
        .fifo_used(used2), .pkt_count(pkt2), .drop_count(dc2), .drop_pulse(dp2));

    assign rx0.tdata = s_tdata;  assign rx0.tlast = s_tlast;  assign rx0.tuser = s_tuser;
    assign rx1.tdata = s_tdata;  assign rx1.tlast = s_tlast;  assign rx1.tuser = s_tuser;
    assign rx2.tdata = s_tdata;  assign rx2.tlast = s_tlast;  assign rx2.tuser = s_tuser;
    assign rx0.tvalid = s_tvalid && (sel == 0);
    assign rx1.tvalid = s_tvalid && (sel == 1);
    assign rx2.tvalid = s_tvalid && (sel == 2);
    assign tx0.tready = m_tready && (sel == 0);
    assign tx1.tready = m_tready && (sel == 1);
    assign tx2.tready = m_tready && (sel == 2);

    logic [31:0] o_tdata;
    logic        o_tvalid, o_tlast, o_tready, o_dpulse;
    logic [6:0]  o_used, o_pkt;
    logic [15:0] o_dcnt;

    always_comb begin
        o_tdata = tx0.tdata; o_tvalid = tx0.tvalid; o_tlast = tx0.tlast; o_tready = rx0.tready;
        o_used = used0; o_pkt = pkt0; o_dcnt = dc0; o_dpulse = dp0;
        if (sel == 1) begin
            o_tdata = tx1.tdata; o_tvalid = tx1.tvalid; o_tlast = tx1.tlast; o_tready = rx1.tready;
            o_used = {2'b00, used1}; o_pkt = {2'b00, pkt1}; o_dcnt = dc1; o_dpulse = dp1;
        end else if (sel == 2) begin
            o_tdata = tx2.tdata; o_tvalid = tx2.tvalid; o_tlast = tx2.tlast; o_tready = rx2.tready;
            o_used = {2'b00, used2}; o_pkt = {2'b00, pkt2}; o_dcnt = dc2; o_dpulse = dp2;
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = 1'($urandom_range(1));
    endtask

    // Drives one packet; good packets are queued on the scoreboard once tlast is accepted.
    task automatic send_pkt(input int len, input logic [31:0] base, input bit user,
                            input bit good, input bit rnd, output int stalls);
        logic [63:0] beats [$];
        bit acc;
        int guard;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            s_tdata  = rnd ? $urandom : base + 32'(i);
            s_tlast  = (i == len - 1);
            s_tuser  = (i == len - 1) ? user : 1'($urandom_range(1));
            s_tvalid = 1'b1;
            beats.push_back(64'({s_tlast, s_tdata}));
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = o_tready;
                if (!acc) stalls++;
                tick();
                guard++;
                if (!acc && guard > 5000) begin
                    check("send_timeout", 64'(acc), 64'd1);
                    s_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        if (good) foreach (beats[k]) sb.push_back(beats[k]);
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while ((sb.size() != 0 || busy || o_tvalid) && guard < 30000) begin
            tick();
            guard++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    logic [63:0] mon_exp;
    logic [63:0] held;
    bit          hold;

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_vld", 64'(o_tvalid), 64'd1);
                check("hold_data", 64'({o_tlast, o_tdata}), held);
            end
            if (o_tvalid && m_tready) begin
                mon_exp = (sb.size() > 0) ? sb.pop_front() : 'x;
                check("rd_data", 64'({o_tlast, o_tdata}), mon_exp);
            end
            hold = o_tvalid && !m_tready;
            held = 64'({o_tlast, o_tdata});
        end
    end

    int st, st5, n_err;
    bit user;
    int len;

    initial begin
        sel = 0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        m_tready = 1'b0; rand_rdy = 1'b0; busy = 1'b0;
        tick(); tick();
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_tready", 64'(o_tready), 64'd0);
        check("rst_used",   64'(o_used),   64'd0);
        check("rst_pkt",    64'(o_pkt),    64'd0);
        check("rst_dcnt",   64'(o_dcnt),   64'd0);
        check("rst_dpulse", 64'(o_dpulse), 64'd0);
        rst = 1'b0;
        tick(); tick();

        // Single packet and commit-to-valid latency
        m_tready = 1'b1;
        send_pkt(5, 32'h10, 1'b0, 1'b1, 1'b0, st);
        check("t1_vld_n1", 64'(o_tvalid), 64'd0);
        check("t1_pkt_1",  64'(o_pkt),    64'd1);
        tick();
        check("t1_vld_n2", 64'(o_tvalid), 64'd1);
        check("t1_first",  64'(o_tdata),  64'h10);
        wait_drain("t1_drain");
        check("t1_pkt_0",  64'(o_pkt),  64'd0);
        check("t1_used_0", 64'(o_used), 64'd0);

        // Errored packet dropped, good packet follows
        m_tready = 1'b0;
        send_pkt(3, 32'h50, 1'b1, 1'b0, 1'b0, st);
        check("t2_dpulse", 64'(o_dpulse), 64'd1);
        check("t2_dcnt",   64'(o_dcnt),   64'd1);
        check("t2_used_rewind", 64'(o_used), 64'd0);
        tick();
        check("t2_dpulse_end", 64'(o_dpulse), 64'd0);
        send_pkt(2, 32'hA0, 1'b0, 1'b1, 1'b0, st);
        check("t2_used_2", 64'(o_used), 64'd2);
        check("t2_pkt_1",  64'(o_pkt),  64'd1);
        tick(); tick();
        check("t2_prefetch", 64'(o_tvalid), 64'd1);
        m_tready = 1'b1;
        wait_drain("t2_drain");
        check("t2_dcnt_end", 64'(o_dcnt), 64'd1);

        // Oversize packet on DEEP=16 with drop enabled
        sel = 1; m_tready = 1'b0;
        send_pkt(20, 32'h100, 1'b0, 1'b0, 1'b0, st);
        check("t3_no_stall", 64'(st),       64'd0);
        check("t3_dcnt",     64'(o_dcnt),   64'd1);
        check("t3_used",     64'(o_used),   64'd0);
        check("t3_pkt",      64'(o_pkt),    64'd0);
        tick(); tick();
        check("t3_no_vld",   64'(o_tvalid), 64'd0);
        m_tready = 1'b1;
        send_pkt(4, 32'h200, 1'b0, 1'b1, 1'b0, st);
        wait_drain("t3_drain");
        check("t3_pkt_end", 64'(o_pkt), 64'd0);

        // Backpressure when full, no drop mode
        sel = 2; m_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_pkt(4, 32'h300 + 32'(16 * k), 1'b0, 1'b1, 1'b0, st);
            check("t4_no_stall", 64'(st), 64'd0);
        end
        busy = 1'b1;
        fork
            begin
                send_pkt(4, 32'h340, 1'b0, 1'b1, 1'b0, st5);
                busy = 1'b0;
            end
        join_none
        repeat (6) tick();
        check("t4_tready_0", 64'(o_tready), 64'd0);
        check("t4_used_16",  64'(o_used),   64'd16);
        check("t4_pkt_4",    64'(o_pkt),    64'd4);
        m_tready = 1'b1;
        wait_drain("t4_drain");
        check("t4_pkt_end",  64'(o_pkt),  64'd0);
        check("t4_used_end", 64'(o_used), 64'd0);

        // Random lengths, errors and output stalls
        rand_rdy = 1'b1; n_err = 0;
        for (int p = 0; p < 2000; p++) begin
            len  = $urandom_range(8, 1);
            user = ($urandom_range(3) == 0);
            if (user) n_err++;
            send_pkt(len, 32'h0, user, !user, 1'b1, st);
        end
        rand_rdy = 1'b0; m_tready = 1'b1;
        wait_drain("t5_drain");
        check("t5_dcnt",     64'(o_dcnt), 64'(n_err));
        check("t5_pkt_end",  64'(o_pkt),  64'd0);
        check("t5_used_end", 64'(o_used), 64'd0);

        // Asynchronous reset with committed packets and one in flight
        sel = 0; m_tready = 1'b0;
        send_pkt(3, 32'h400, 1'b0, 1'b1, 1'b0, st);
        send_pkt(3, 32'h410, 1'b0, 1'b1, 1'b0, st);
        s_tdata = 32'h4F0; s_tlast = 1'b0; s_tvalid = 1'b1;
        tick(); tick();
        check("t6_pkt_pre",  64'(o_pkt),  64'd2);
        check("t6_dcnt_pre", 64'(o_dcnt), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_tvalid", 64'(o_tvalid), 64'd0);
        check("t6_pkt",    64'(o_pkt),    64'd0);
        check("t6_used",   64'(o_used),   64'd0);
        check("t6_dcnt",   64'(o_dcnt),   64'd0);
        sb.delete();
        s_tvalid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        m_tready = 1'b1;
        send_pkt(3, 32'h420, 1'b0, 1'b1, 1'b0, st);
        wait_drain("t6_drain");
        check("t6_pkt_end", 64'(o_pkt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
